// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with a tear-free shadow of the BCD count.
// Define FND_LZB_EN to blank leading zeros on digits 3 and 2.
module fnd_scan_driver #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLANK_CYC   = 500,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned COM_ACT_LOW = 1
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [15:0] iDATA_CNT,
  input  logic [3:0]  iDP,
  input  logic        iBLANK,
  output logic [7:0]  oSEG,
  output logic [3:0]  oCOM,
  output logic        oFRAME
);

  localparam int unsigned    CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
  localparam logic [7:0]     SEG_MASK  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]     COM_MASK  = (COM_ACT_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [3:0]    dp_shadow;

  logic [3:0] nib;
  logic [6:0] glyph;
  logic       digit_dark;
  logic       lit;
  logic       load;
  logic [7:0] seg_next;
  logic [3:0] com_next;

  always_comb begin
    nib        = 4'h0;
    glyph      = 7'h40;
    digit_dark = 1'b0;
    case (idx)
      2'd0:    nib = shadow[3:0];
      2'd1:    nib = shadow[7:4];
      2'd2:    nib = shadow[11:8];
      default: nib = shadow[15:12];
    endcase
    case (nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
`ifdef FND_LZB_EN
    // Only the glyph is suppressed; a requested dp stays visible.
    digit_dark = ((idx == 2'd3) && (shadow[15:12] == 4'h0)) ||
                 ((idx == 2'd2) && (shadow[15:8] == 8'h00));
`else
    digit_dark = 1'b0;
`endif
    load     = (idx == 2'd3) && (cnt == CNT_LAST);
    lit      = !iBLANK && (cnt >= BLANK_END);
    seg_next = (lit ? {dp_shadow[idx], (digit_dark ? 7'h00 : glyph)} : 8'h00) ^ SEG_MASK;
    com_next = (lit ? (4'b0001 << idx) : 4'h0) ^ COM_MASK;
  end

  always_ff @(posedge iCLK) begin
    if (iRESETn) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      dp_shadow <= 4'h0;
      oSEG      <= SEG_MASK;
      oCOM      <= COM_MASK;
      oFRAME    <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Take the new count only at the very end of digit 3 so a frame never tears.
      if (load) begin
        shadow    <= iDATA_CNT;
        dp_shadow <= iDP;
      end
      oFRAME <= load;
      oSEG   <= seg_next;
      oCOM   <= com_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver (SCAN_DIV=8, BLANK_CYC=2, active-low outputs).
// A cycle-position model predicts every output; literal checks pin the model.
module tb_fnd_scan_driver;

  localparam int FRAME = 32;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        blank;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic        frame;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic checking = 1'b0;

  fnd_scan_driver #(
    .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACT_LOW(1), .COM_ACT_LOW(1)
  ) dut (
    .iCLK(clk), .iRESETn(rst), .iDATA_CNT(data), .iDP(dp), .iBLANK(blank),
    .oSEG(seg), .oCOM(com), .oFRAME(frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: absolute cycle position since reset, and the value latched at each frame end.
  int          n        = 0;
  int          pos_q    = 0;
  logic        in_reset = 1'b1;
  logic        blank_q  = 1'b0;
  logic        frame_q  = 1'b0;
  logic [15:0] msh      = 16'h0;
  logic [3:0]  mdp      = 4'h0;
  logic [15:0] shown_sh = 16'h0;
  logic [3:0]  shown_dp = 4'h0;

  always @(posedge clk) begin
    if (rst) begin
      n        <= 0;
      pos_q    <= 0;
      in_reset <= 1'b1;
      blank_q  <= 1'b0;
      frame_q  <= 1'b0;
      msh      <= 16'h0;
      mdp      <= 4'h0;
      shown_sh <= 16'h0;
      shown_dp <= 4'h0;
    end else begin
      in_reset <= 1'b0;
      n        <= n + 1;
      pos_q    <= n % FRAME;
      blank_q  <= blank;
      frame_q  <= ((n % FRAME) == FRAME - 1);
      shown_sh <= msh;
      shown_dp <= mdp;
      if ((n % FRAME) == FRAME - 1) begin
        msh <= data;
        mdp <= dp;
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] es;
    logic [3:0] ec;
    logic       ef;
    logic       dark;
    logic       lit;
    logic [6:0] g;
    int         dg;
    int         off;
    int         nib;
    if (checking) begin
      if (in_reset) begin
        es = 8'hFF;
        ec = 4'hF;
        ef = 1'b0;
      end else begin
        dg  = pos_q / SLOT;
        off = pos_q % SLOT;
        nib = int'((shown_sh >> (4 * dg)) & 16'h000F);
        g   = (nib < 10) ? GLYPH[nib] : 7'h40;
`ifdef FND_LZB_EN
        dark = (dg == 3 && shown_sh < 16'h1000) || (dg == 2 && shown_sh < 16'h0100);
`else
        dark = 1'b0;
`endif
        lit = !blank_q && (off >= BLANK);
        es  = lit ? ~{shown_dp[dg], (dark ? 7'h00 : g)} : 8'hFF;
        ec  = lit ? ~(4'b0001 << dg) : 4'hF;
        ef  = frame_q;
      end
      check_output("model_seg", seg, es);
      check_output("model_com", {4'h0, com}, {4'h0, ec});
      check_output("model_frame", {7'h0, frame}, {7'h0, ef});
    end
  end

  task automatic wait_pos(input int p);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (!in_reset && pos_q == p) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_pos: position %0d not reached within 200 cycles", p);
    end
  endtask

  task automatic wait_frame(output int t);
    bit found = 1'b0;
    t = cyc;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        found = 1'b1;
        t = cyc;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_frame: no oFRAME pulse within 200 cycles");
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p);
    data = d;
    dp   = p;
  endtask

  initial begin
    int t0;
    int t1;
    rst   = 1'b1;
    data  = 16'h0000;
    dp    = 4'h0;
    blank = 1'b0;
    @(posedge clk);
    checking = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_com", {4'h0, com}, 8'h0F);
    check_output("reset_seg", seg, 8'hFF);
    check_output("reset_frame", {7'h0, frame}, 8'h00);

    apply_stimulus(16'h5959, 4'h0);
    rst = 1'b0;
    wait_pos(1);
    check_output("first_dark_com", {4'h0, com}, 8'h0F);
    wait_pos(2);
    check_output("first_lit_com", {4'h0, com}, 8'h0E);
    wait_pos(10);
    check_output("digit1_com", {4'h0, com}, 8'h0D);
    wait_frame(t0);

    wait_pos(4);  check_output("d0_5959", seg, 8'h90);
    wait_pos(12); check_output("d1_5959", seg, 8'h92);
    wait_pos(20); check_output("d2_5959", seg, 8'h90);
    check_output("digit2_com", {4'h0, com}, 8'h0B);
    wait_pos(28); check_output("d3_5959", seg, 8'h92);
    check_output("digit3_com", {4'h0, com}, 8'h07);
    apply_stimulus(16'h1234, 4'h0);
    wait_frame(t1);
    check_output("frame_period", 8'(t1 - t0), 8'd32);

    wait_pos(4);  check_output("d0_1234", seg, 8'h99);
    wait_pos(12);
    apply_stimulus(16'h0000, 4'h0);
    check_output("d1_1234", seg, 8'hB0);
    wait_pos(20); check_output("d2_1234_held", seg, 8'hA4);
    wait_pos(28); check_output("d3_1234_held", seg, 8'hF9);

    wait_pos(4);  check_output("d0_0000", seg, 8'hC0);
    wait_pos(28);
`ifdef FND_LZB_EN
    check_output("d3_0000_lzb", seg, 8'hFF);
`else
    check_output("d3_0000", seg, 8'hC0);
`endif
    apply_stimulus(16'h00AB, 4'b0100);

    wait_pos(4);  check_output("d0_B_dash", seg, 8'hBF);
    wait_pos(12); check_output("d1_A_dash", seg, 8'hBF);
    wait_pos(20);
`ifdef FND_LZB_EN
    check_output("d2_zero_dp_lzb", seg, 8'h7F);
`else
    check_output("d2_zero_dp", seg, 8'h40);
`endif

    wait_frame(t0);
    wait_pos(3);
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("blank_com", {4'h0, com}, 8'h0F);
      check_output("blank_seg", seg, 8'hFF);
      if (i == 2) blank = 1'b0;
    end
    @(negedge clk);
    check_output("unblank_com", {4'h0, com}, 8'h0E);
    wait_frame(t1);
    check_output("frame_period_blank", 8'(t1 - t0), 8'd32);

    wait_pos(20);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset_com", {4'h0, com}, 8'h0F);
    check_output("midreset_seg", seg, 8'hFF);
    rst = 1'b0;
    wait_pos(1);
    check_output("restart_dark_com", {4'h0, com}, 8'h0F);
    wait_pos(2);
    check_output("restart_lit_com", {4'h0, com}, 8'h0E);
    wait_pos(4);
    check_output("restart_shadow_zero", seg, 8'hC0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- 4-digit multiplexed 7-segment (FND) display driver. It consumes the 16-bit packed BCD count produced by the watch's BCD counter: digit 3 is the MSB nibble, digit 0 the LSB nibble.
- It latches the count tear-free, time-multiplexes the four common lines, and decodes each nibble to segment patterns.
- It sits between the counter and the board FND pins and is the display-side end of the count bus.

Parameters:
- SCAN_DIV, 50000, iCLK cycles each digit is selected (>= BLANK_CYC+2).
- BLANK_CYC, 500, anti-ghosting cycles at the start of each digit slot with all commons off (>= 1).
- SEG_ACT_LOW, 1, 1 = segment lit when its bit is 0.
- COM_ACT_LOW, 1, 1 = digit selected when its oCOM bit is 0.

Ports:
- iCLK  in  1  system clock
- iRESETn  in  1  reset; synchronous, active-high despite the name
- iDATA_CNT  in  16  packed BCD {d3,d2,d1,d0}
- iDP  in  4  per-digit decimal point request; bit n maps to digit n
- iBLANK  in  1  1 = force display dark; scanning continues
- oSEG  out  8  {dp,g,f,e,d,c,b,a}
- oCOM  out  4  digit commons; bit n maps to digit n
- oFRAME  out  1  one-cycle pulse when a new shadow value is taken

Behaviour:
- Reset (iRESETn=1 at a posedge):
  - prescaler cnt=0, digit index idx=0, shadow register=16'h0000, dp shadow=0.
  - oCOM = all inactive (4'hF when COM_ACT_LOW), oSEG = all off (8'hFF when SEG_ACT_LOW), oFRAME=0.
  - Reset mid-frame aborts the slot immediately. The first lit digit after reset is digit 0 at cnt=BLANK_CYC.
- Prescaler:
  - cnt runs 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx advances 0->1->2->3->0.
- Shadow load:
  - When idx==3 and cnt==SCAN_DIV-1, the shadow register takes iDATA_CNT and the dp shadow takes iDP.
  - oFRAME pulses on the following cycle.
  - iDATA_CNT changes mid-frame never affect the frame in progress.
- Commons:
  - While cnt < BLANK_CYC, all commons are inactive.
  - Otherwise exactly one common is active: oCOM bit idx.
- Decode (active-high {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Non-BCD nibble A-F displays '-' (40).
  - dp bit = dp shadow bit idx.
- Polarity: patterns are inverted when SEG_ACT_LOW=1.
- iBLANK:
  - When 1, commons are inactive and segments are off.
  - Sampled every cycle with the same one-cycle latency as the other outputs. Does not disturb cnt, idx or the shadow register.
- Latency: oSEG, oCOM and oFRAME are registered and reflect (cnt, idx, shadow, iBLANK) from the previous cycle.
- Segments change only when commons are inactive (slot boundary), so no ghosting.

Optional Feature:
- FND_LZB_EN defined: leading-zero blanking.
  - Digit 3 is dark (segments off, common still cycles) when its nibble is 0.
  - Digit 2 is also dark when digits 3 and 2 are both 0.
  - A requested dp on a blanked digit still lights the dp segment.
  - Digits 1 and 0 are always shown.
- FND_LZB_EN undefined: all four digits are always decoded; 0 shows as 3F.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, active-low polarity):
- Reset held 3 cycles, then released -> oCOM=F, oSEG=FF. Then 2 dark cycles, then oCOM=E for 6 cycles; the sequence repeats D, B, 7 with 2 dark cycles before each.
- iDATA_CNT=16'h5959 applied before the first frame end -> oFRAME pulses once per 32 cycles. Next frame shows oSEG digit0=90, digit1=92, digit2=90, digit3=92.
- iDATA_CNT changed 16'h1234 -> 16'h0000 at cycle 12 of a frame -> the current frame still shows 4/3/2/1 (99, B0, A4, F9). The next frame shows C0 on all digits (without FND_LZB_EN).
- iDATA_CNT=16'h00AB, iDP=4'b0100 -> digits 0 and 1 show BF ('-'); digit 2 shows 40 (0 with dp) without FND_LZB_EN, or 7F with it.
- iBLANK pulsed high for 3 cycles mid-slot -> oCOM=F and oSEG=FF for exactly 3 cycles, delayed by 1 cycle. Slot timing and oFRAME spacing are unchanged.
- Reset asserted at idx=2, cnt=5 -> next cycle outputs are dark and shadow=0000. The scan restarts at digit 0 with a full blank interval.
